fetch_controller: RTL and testbench

Sequencer for the instruction-fetch datapath. It owns the program counter, addresses the combinational instruction ROM, and registers each fetched word with its PC into an output stage toward decode under a valid/ready handshake. It applies branch redirects with a one-bubble flush, stops on a HALT opcode until restarted, and keeps a saturating retired-fetch counter. It sits between `instr_rom` and decode and replaces the free-running PC in the fetch top.

---
 rtl/fetch_pkg.sv | 5 +
 rtl/sat_counter.sv | 14 +
 rtl/fetch_controller.sv | 59 +++++
 tb/tb_fetch_controller.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and opcode constants for the fetch sequencer
package fetch_pkg;
  typedef enum logic [1:0] {FC_IDLE, FC_RUN, FC_HALT} fetch_state_t;
  localparam logic [7:0] HALT_OPCODE = 8'hFF;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk) begin
    if (!reset) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
  end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: owns the PC, registers ROM words toward decode, handles branch flush, HALT and retired count
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  branch_en,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  fetch_count
);
  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  slot_free, capture, is_halt;
  assign slot_free = !out_valid || out_ready;
  assign capture   = (state == FC_RUN) && slot_free && !branch_en;
  assign is_halt   = rom_data[DATA_WIDTH-1 -: 8] == HALT_OPCODE;
  assign rom_addr  = pc;
  assign halted    = state == FC_HALT;
  // a free slot that does not capture drains: branch bubble, or last word leaving in IDLE/HALT
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FC_IDLE;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else begin
      if (branch_en) begin
        pc        <= branch_addr;
        out_valid <= 1'b0;
      end else if (capture) begin
        out_instr <= rom_data;
        out_pc    <= pc;
        out_valid <= 1'b1;
        pc        <= pc + 1'b1;
      end else if (slot_free) out_valid <= 1'b0;
      state <= (state != FC_RUN && start) ? FC_RUN : (capture && is_halt) ? FC_HALT : state;
    end
  end
  sat_counter #(.WIDTH(CNT_WIDTH)) u_count (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid && out_ready && !branch_en),
    .count (fetch_count)
  );
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed scenarios plus a randomized transaction-stream scoreboard
module tb_fetch_controller;
  logic        clk, reset, start, branch_en, out_ready;
  logic [7:0]  branch_addr, rom_addr, out_pc, rom_addr2, out_pc2;
  logic [31:0] rom_data, out_instr, rom_data2, out_instr2;
  logic        out_valid, halted, out_valid2, halted2;
  logic [15:0] fetch_count;
  logic [3:0]  fetch_count2;
  logic [31:0] rom [256];
  int          checks = 0, passed = 0;

  assign rom_data  = rom[rom_addr];
  assign rom_data2 = {8'h00, rom_addr2, rom_addr2, rom_addr2};

  fetch_controller dut (
    .clk(clk), .reset(reset), .start(start), .branch_en(branch_en), .branch_addr(branch_addr),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .halted(halted), .fetch_count(fetch_count)
  );

  fetch_controller #(.RESET_PC(8'hFE), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .reset(reset), .start(start), .branch_en(branch_en), .branch_addr(branch_addr),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_instr(out_instr2), .out_pc(out_pc2), .halted(halted2), .fetch_count(fetch_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic rom_pattern;
    for (int a = 0; a < 256; a++) rom[a] = a * 32'h01010101;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; branch_en = 1'b0; branch_addr = '0; out_ready = 1'b0;
    step; step;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else passed++;
    checks++; if (out_instr !== 32'h0) $display("FAIL reset_instr got %h exp 0", out_instr); else passed++;
    checks++; if (out_pc !== 8'h0) $display("FAIL reset_pc got %h exp 0", out_pc); else passed++;
    checks++; if (halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", halted); else passed++;
    checks++; if (fetch_count !== 16'h0) $display("FAIL reset_count got %0d exp 0", fetch_count); else passed++;
    checks++; if (rom_addr !== 8'h00) $display("FAIL reset_rom_addr got %h exp 00", rom_addr); else passed++;
    checks++; if (rom_addr2 !== 8'hFE) $display("FAIL reset_rom_addr2 got %h exp fe", rom_addr2); else passed++;
  endtask

  task automatic test_start_stream;
    reset = 1'b1; out_ready = 1'b1; start = 1'b1;
    step;
    start = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL start_latency got valid %b exp 0", out_valid); else passed++;
    step;
    checks++; if (out_valid !== 1'b1 || out_pc !== 8'h0) $display("FAIL first_fetch got v%b pc %h exp v1 pc 00", out_valid, out_pc); else passed++;
    for (int i = 1; i <= 5; i++) begin
      step;
      checks++; if (out_pc !== 8'(i) || out_instr !== i * 32'h01010101) $display("FAIL stream got pc %h instr %h exp pc %h", out_pc, out_instr, 8'(i)); else passed++;
      checks++; if (fetch_count !== 16'(i)) $display("FAIL stream_count got %0d exp %0d", fetch_count, i); else passed++;
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++; if (out_valid !== 1'b1 || out_pc !== 8'h05 || out_instr !== 32'h05050505) $display("FAIL bp_hold got v%b pc %h instr %h exp v1 pc 05", out_valid, out_pc, out_instr); else passed++;
      checks++; if (rom_addr !== 8'h06) $display("FAIL bp_pc got %h exp 06", rom_addr); else passed++;
    end
    out_ready = 1'b1;
    step;
    checks++; if (out_pc !== 8'h06 || fetch_count !== 16'd6) $display("FAIL bp_release got pc %h count %0d exp pc 06 count 6", out_pc, fetch_count); else passed++;
  endtask

  task automatic test_branch;
    int c;
    branch_en = 1'b1; branch_addr = 8'h03;
    step;
    branch_en = 1'b0;
    step;
    checks++; if (out_valid !== 1'b1 || out_pc !== 8'h03) $display("FAIL br_setup got v%b pc %h exp v1 pc 03", out_valid, out_pc); else passed++;
    c = fetch_count;
    branch_en = 1'b1; branch_addr = 8'h40;
    step;
    branch_en = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL br_bubble got valid %b exp 0", out_valid); else passed++;
    checks++; if (fetch_count !== 16'(c)) $display("FAIL br_uncounted got %0d exp %0d", fetch_count, c); else passed++;
    step;
    checks++; if (out_valid !== 1'b1 || out_pc !== 8'h40 || out_instr !== 32'h40404040) $display("FAIL br_target got v%b pc %h exp v1 pc 40", out_valid, out_pc); else passed++;
    step;
    checks++; if (out_pc !== 8'h41 || fetch_count !== 16'(c + 1)) $display("FAIL br_next got pc %h count %0d exp pc 41 count %0d", out_pc, fetch_count, c + 1); else passed++;
  endtask

  task automatic test_random;
    logic [7:0]  exp_next, hp;
    logic [31:0] hi;
    logic        hold, br;
    int          c0, n;
    for (int a = 0; a < 256; a++) rom[a] = {8'($urandom_range(0, 254)), 24'($urandom)};
    out_ready = 1'b1; branch_en = 1'b1; branch_addr = 8'($urandom);
    exp_next = branch_addr;
    step;
    branch_en = 1'b0;
    c0 = fetch_count; n = 0;
    for (int i = 0; i < 300; i++) begin
      out_ready = $urandom_range(0, 3) != 0;
      br = $urandom_range(0, 7) == 0;
      branch_en = br; branch_addr = 8'($urandom);
      if (out_valid && out_ready && !br) begin
        checks++; if (out_pc !== exp_next) $display("FAIL rnd_order got pc %h exp %h", out_pc, exp_next); else passed++;
        checks++; if (out_instr !== rom[exp_next]) $display("FAIL rnd_data got %h exp %h", out_instr, rom[exp_next]); else passed++;
        exp_next = exp_next + 1'b1;
        n++;
      end
      if (br) exp_next = branch_addr;
      hold = out_valid && !out_ready && !br; hp = out_pc; hi = out_instr;
      step;
      if (br) begin
        checks++; if (out_valid !== 1'b0) $display("FAIL rnd_flush got valid %b exp 0", out_valid); else passed++;
      end
      if (hold) begin
        checks++; if (out_valid !== 1'b1 || out_pc !== hp || out_instr !== hi) $display("FAIL rnd_stall got pc %h instr %h exp pc %h instr %h", out_pc, out_instr, hp, hi); else passed++;
      end
    end
    branch_en = 1'b0;
    checks++; if (fetch_count !== 16'(c0 + n)) $display("FAIL rnd_count got %0d exp %0d", fetch_count, c0 + n); else passed++;
  endtask

  task automatic test_halt;
    int c;
    rom_pattern;
    rom[7] = 32'hFF000000;
    out_ready = 1'b1; branch_en = 1'b1; branch_addr = 8'h05;
    step;
    branch_en = 1'b0;
    c = fetch_count;
    step; step;
    checks++; if (out_pc !== 8'h06 || halted !== 1'b0) $display("FAIL halt_pre got pc %h halted %b exp pc 06 halted 0", out_pc, halted); else passed++;
    step;
    checks++; if (out_valid !== 1'b1 || out_pc !== 8'h07 || out_instr !== 32'hFF000000 || halted !== 1'b1) $display("FAIL halt_word got v%b pc %h halted %b exp v1 pc 07 halted 1", out_valid, out_pc, halted); else passed++;
    step;
    checks++; if (out_valid !== 1'b0 || halted !== 1'b1 || rom_addr !== 8'h08) $display("FAIL halt_stop got v%b halted %b pc %h exp v0 halted 1 pc 08", out_valid, halted, rom_addr); else passed++;
    step;
    checks++; if (out_valid !== 1'b0 || fetch_count !== 16'(c + 3)) $display("FAIL halt_idle got v%b count %0d exp v0 count %0d", out_valid, fetch_count, c + 3); else passed++;
    start = 1'b1;
    step;
    start = 1'b0;
    checks++; if (halted !== 1'b0 || out_valid !== 1'b0) $display("FAIL halt_resume got halted %b v%b exp 0 0", halted, out_valid); else passed++;
    step;
    checks++; if (out_valid !== 1'b1 || out_pc !== 8'h08) $display("FAIL halt_next got v%b pc %h exp v1 pc 08", out_valid, out_pc); else passed++;
  endtask

  task automatic test_wrap_saturate;
    logic [7:0] e;
    int         n;
    reset = 1'b0;
    step;
    reset = 1'b1; start = 1'b1; out_ready = 1'b1;
    step;
    start = 1'b0;
    step;
    e = 8'hFE; n = 0;
    checks++; if (out_valid2 !== 1'b1 || out_pc2 !== e) $display("FAIL wrap_first got v%b pc %h exp v1 pc fe", out_valid2, out_pc2); else passed++;
    for (int i = 0; i < 20; i++) begin
      if (out_valid2 && out_ready) n++;
      step;
      e = e + 1'b1;
      checks++; if (out_pc2 !== e) $display("FAIL wrap_pc got %h exp %h", out_pc2, e); else passed++;
      checks++; if (fetch_count2 !== 4'(n > 15 ? 15 : n)) $display("FAIL sat_count got %0d exp %0d", fetch_count2, n > 15 ? 15 : n); else passed++;
    end
  endtask

  task automatic test_reset_mid;
    branch_en = 1'b1; branch_addr = 8'h20; start = 1'b1; out_ready = 1'b1;
    step;
    branch_en = 1'b0; start = 1'b0;
    step;
    checks++; if (out_valid !== 1'b1 || out_pc !== 8'h20) $display("FAIL rmid_setup got v%b pc %h exp v1 pc 20", out_valid, out_pc); else passed++;
    reset = 1'b0; branch_en = 1'b1; branch_addr = 8'h40; start = 1'b1;
    step;
    reset = 1'b1; branch_en = 1'b0; start = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_pc !== 8'h0 || out_instr !== 32'h0 || halted !== 1'b0) $display("FAIL rmid_outputs got v%b pc %h instr %h halted %b exp all 0", out_valid, out_pc, out_instr, halted); else passed++;
    checks++; if (fetch_count !== 16'h0 || rom_addr !== 8'h00) $display("FAIL rmid_state got count %0d pc %h exp 0 00", fetch_count, rom_addr); else passed++;
    step; step;
    checks++; if (out_valid !== 1'b0 || rom_addr !== 8'h00) $display("FAIL rmid_idle got v%b pc %h exp v0 pc 00", out_valid, rom_addr); else passed++;
  endtask

  initial begin
    rom_pattern;
    test_reset;
    test_start_stream;
    test_backpressure;
    test_branch;
    test_random;
    test_halt;
    test_wrap_saturate;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
